// File: rtl/bsg_muxi2_pipe_stage_if.sv
// Handshake bundle for bsg_muxi2_pipe_stage.
// Signal suffixes are taken from the stage's point of view: _i is driven into
// the stage, _o is driven by the stage.
// The slave modport is the stage side. The master modport is the
// producer/consumer side.
interface bsg_muxi2_pipe_stage_if #(
   parameter int width_p = 64
);
   // producer side
   logic               v_i;
   logic               ready_o;
   logic [width_p-1:0] data0_i;
   logic [width_p-1:0] data1_i;
   logic [width_p-1:0] sel_i;

   // consumer side
   logic               v_o;
   logic [width_p-1:0] data_o;
   logic               yumi_i;
   logic [1:0]         count_o;

   modport slave (
      input  v_i, data0_i, data1_i, sel_i, yumi_i,
      output ready_o, v_o, data_o, count_o
   );

   modport master (
      output v_i, data0_i, data1_i, sel_i, yumi_i,
      input  ready_o, v_o, data_o, count_o
   );
endinterface

// File: rtl/bsg_muxi2_pipe_stage.sv
// bsg_muxi2_pipe_stage: registered valid/ready stage around a per-bit
// inverting 2:1 select, backed by a 2-entry FIFO.
//
// Optional build macro: BSG_MUXI2_PIPE_UNINVERT_EN
//   defined   -> the stored result is the true-polarity select
//   undefined -> the stored result is the inverted select (default)
// Handshake, latency and occupancy are the same in both builds.

// One bit of the select gatestack.
module bsg_muxi2_pipe_stage_lane (
   input  logic d0_i,
   input  logic d1_i,
   input  logic sel_i,
   output logic r_o
);
`ifdef BSG_MUXI2_PIPE_UNINVERT_EN
   assign r_o = sel_i ? d1_i : d0_i;
`else
   assign r_o = ~(sel_i ? d1_i : d0_i);
`endif
endmodule

module bsg_muxi2_pipe_stage #(
   parameter int width_p = 64
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   bsg_muxi2_pipe_stage_if.slave   io
);

   typedef struct packed {
      logic [width_p-1:0] data0;
      logic [width_p-1:0] data1;
      logic [width_p-1:0] sel;
   } beat_s;

   beat_s                         beat;
   logic [width_p-1:0]            res;

   logic [1:0][width_p-1:0]       entry_q;
   logic                          rd_ptr_q, rd_ptr_d;
   logic                          wr_ptr_q, wr_ptr_d;
   logic                          full_q,   full_d;
   logic                          enq, deq;
   logic [1:0]                    count;

   assign beat.data0 = io.data0_i;
   assign beat.data1 = io.data1_i;
   assign beat.sel   = io.sel_i;

   // The select logic feeds only the entry write port. Operands are never
   // stored; only the result is written.
   for (genvar b = 0; b < width_p; b++) begin : g_lane
      bsg_muxi2_pipe_stage_lane lane (
         .d0_i  (beat.data0[b]),
         .d1_i  (beat.data1[b]),
         .sel_i (beat.sel[b]),
         .r_o   (res[b])
      );
   end

   // ready_o does not look at yumi_i, so a full buffer never passes a beat
   // through in the same cycle. The reset gate holds it low during reset.
   assign io.ready_o = ~full_q & ~reset_i;

   // Occupancy comes from the pointers and the full flag. When the pointers
   // are equal, full_q tells the two-entry case apart from the empty case.
   always_comb begin
      count = 2'd0;
      if (full_q)                  count = 2'd2;
      else if (rd_ptr_q != wr_ptr_q) count = 2'd1;
   end

   assign io.count_o = count;
   assign io.v_o     = (count != 2'd0);
   assign io.data_o  = entry_q[rd_ptr_q];

   // A yumi_i without valid data is masked here, so it cannot move rd_ptr.
   assign enq = io.v_i & io.ready_o;
   assign deq = io.yumi_i & io.v_o;

   // Next pointer and full state. The 1-bit pointers wrap from 1 back to 0.
   always_comb begin
      rd_ptr_d = rd_ptr_q ^ deq;
      wr_ptr_d = wr_ptr_q ^ enq;
      full_d   = full_q;
      if (enq & ~deq & ((wr_ptr_q ^ 1'b1) == rd_ptr_q)) full_d = 1'b1;
      else if (deq & ~enq)                              full_d = 1'b0;
   end

   // Pointer and flag registers. Reset is asynchronous, so an active reset
   // discards buffered beats at once.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         full_q   <= full_d;
      end
   end

   // Entry storage. Entries are cleared on reset so that data_o reads 0.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         entry_q <= '0;
      end else if (enq) begin
         entry_q[wr_ptr_q] <= res;
      end
   end

endmodule

// File: tb/tb_bsg_muxi2_pipe_stage.sv
// Scoreboard bench for bsg_muxi2_pipe_stage with width_p=8.
// The driver pushes expected results when a beat is offered to a model with
// space. A separate monitor checks occupancy and the head value, and pops an
// entry on each legal take.
module tb_bsg_muxi2_pipe_stage;
   logic clk = 1'b0;
   logic reset;
   always #10 clk = ~clk;

   bsg_muxi2_pipe_stage_if #(.width_p(8)) bus ();

   bsg_muxi2_pipe_stage #(.width_p(8)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .io      (bus)
   );

   int         errs   = 0;
   int         checks = 0;
   logic [7:0] sb[$];
   bit         enq_pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: pick data1 where the select bit is 1, else data0, then apply
   // the build's polarity.
   function automatic logic [7:0] model(input logic [7:0] d0, input logic [7:0] d1,
                                        input logic [7:0] s);
      logic [7:0] r;
      r = (s & d1) | (~s & d0);
`ifndef BSG_MUXI2_PIPE_UNINVERT_EN
      r = ~r;
`endif
      return r;
   endfunction

   // Drive one cycle of inputs on the falling edge, then record acceptance
   // in the model.
   task automatic cyc(input bit v, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] s, input bit y);
      @(negedge clk);
      bus.v_i     = v;
      bus.data0_i = d0;
      bus.data1_i = d1;
      bus.sel_i   = s;
      bus.yumi_i  = y;
      #1;
      chk("ready_o", 32'(bus.ready_o), 32'(sb.size() < 2));
      enq_pend = v && (sb.size() < 2);
      if (enq_pend) sb.push_back(model(d0, d1, s));
   endtask

   task automatic peek(input string nm, input logic [7:0] exp);
      chk({nm, "_v"}, 32'(bus.v_o), 32'd1);
      chk({nm, "_data"}, 32'(bus.data_o), 32'(exp));
   endtask

   // Monitor: occupancy, valid and head value come from the model, which is
   // the state before this cycle's enqueue.
   always @(negedge clk) begin : mon
      int occ;
      #2;
      if (!reset) begin
         occ = sb.size() - int'(enq_pend);
         chk("count_o", 32'(bus.count_o), 32'(occ));
         chk("v_o", 32'(bus.v_o), 32'(occ != 0));
         if (occ > 0) chk("data_o", 32'(bus.data_o), 32'(sb[0]));
         if (bus.yumi_i && occ > 0) void'(sb.pop_front());
      end
   end

   initial begin
      bus.v_i = 1'b0; bus.yumi_i = 1'b0;
      bus.data0_i = '0; bus.data1_i = '0; bus.sel_i = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #12;
      chk("rst_v_o", 32'(bus.v_o), 32'd0);
      chk("rst_count_o", 32'(bus.count_o), 32'd0);
      chk("rst_data_o", 32'(bus.data_o), 32'd0);
      chk("rst_ready_o", 32'(bus.ready_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("rel_ready_o", 32'(bus.ready_o), 32'd1);

      // single beats
      cyc(1, 8'hF0, 8'h0F, 8'hFF, 0);
      cyc(0, 8'h00, 8'h00, 8'h00, 1);
`ifdef BSG_MUXI2_PIPE_UNINVERT_EN
      peek("sel_ff", 8'h0F);
`else
      peek("sel_ff", 8'hF0);
`endif
      cyc(1, 8'hF0, 8'h0F, 8'h00, 0);
      cyc(0, 8'h00, 8'h00, 8'h00, 1);
`ifdef BSG_MUXI2_PIPE_UNINVERT_EN
      peek("sel_00", 8'hF0);
`else
      peek("sel_00", 8'h0F);
`endif
      cyc(1, 8'hF0, 8'h0F, 8'hAA, 0);
      cyc(0, 8'h00, 8'h00, 8'h00, 1);
`ifdef BSG_MUXI2_PIPE_UNINVERT_EN
      peek("sel_aa", 8'h5A);
`else
      peek("sel_aa", 8'hA5);
`endif

      // fill and stall
      cyc(1, 8'h11, 8'h22, 8'h0F, 0);
      cyc(1, 8'h33, 8'h44, 8'hF0, 0);
      cyc(1, 8'h55, 8'h66, 8'hAA, 0);
      chk("full_count_o", 32'(bus.count_o), 32'd2);
      chk("full_ready_o", 32'(bus.ready_o), 32'd0);
      peek("hold0", model(8'h11, 8'h22, 8'h0F));
      cyc(0, 8'h00, 8'h00, 8'h00, 0);
      peek("hold1", model(8'h11, 8'h22, 8'h0F));
      cyc(0, 8'h00, 8'h00, 8'h00, 1);
      cyc(0, 8'h00, 8'h00, 8'h00, 0);
      peek("second", model(8'h33, 8'h44, 8'hF0));
      cyc(0, 8'h00, 8'h00, 8'h00, 1);

      // streaming with pointer wrap
      for (int i = 0; i < 16; i++) begin
         cyc(1, 8'h00, 8'(i + 1), 8'hFF, 1);
         if (i > 0) chk("stream_count_o", 32'(bus.count_o), 32'd1);
      end
      cyc(0, 8'h00, 8'h00, 8'h00, 1);

      // illegal yumi on an empty buffer
      for (int i = 0; i < 3; i++) begin
         cyc(0, 8'h00, 8'h00, 8'h00, 1);
         chk("illegal_count_o", 32'(bus.count_o), 32'd0);
         chk("illegal_v_o", 32'(bus.v_o), 32'd0);
      end
      cyc(1, 8'h3C, 8'hC3, 8'h55, 0);
      cyc(0, 8'h00, 8'h00, 8'h00, 1);
      peek("after_illegal", model(8'h3C, 8'hC3, 8'h55));

      // reset between clock edges while full
      cyc(1, 8'hAB, 8'hCD, 8'h3C, 0);
      cyc(1, 8'h12, 8'h34, 8'hC3, 0);
      @(negedge clk);
      bus.v_i = 1'b0; bus.yumi_i = 1'b0; enq_pend = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_v_o", 32'(bus.v_o), 32'd0);
      chk("mid_rst_count_o", 32'(bus.count_o), 32'd0);
      chk("mid_rst_data_o", 32'(bus.data_o), 32'd0);
      sb.delete();
      #1 reset = 1'b0;
      #1 chk("mid_rel_ready_o", 32'(bus.ready_o), 32'd1);
      cyc(1, 8'h5A, 8'hA5, 8'h0F, 0);
      cyc(0, 8'h00, 8'h00, 8'h00, 1);
      peek("post_rst", model(8'h5A, 8'hA5, 8'h0F));

      // random traffic, including occasional illegal yumi
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)));
      repeat (3) cyc(0, 8'h00, 8'h00, 8'h00, 1);
      cyc(0, 8'h00, 8'h00, 8'h00, 0);
      chk("drain_count_o", 32'(bus.count_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
